lal_counter: RTL
================

LAL_COUNTER -- requirements
Module: lal_counter

Interface
REQ-001 Parameter WIDTH, default 9: count/limit width; legal 2..32.
REQ-002 Parameter CMP_W, default 4: compare operand width; legal 1..16.
REQ-003 clk  input  1  sole clock; all state rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a run from IDLE.
REQ-006 abort  input  1  terminate run, return to IDLE.
REQ-007 inhibit  input  1  freeze count while high.
REQ-008 load  input  1  load cnt from load_val.
REQ-009 load_val  input  WIDTH  load value.
REQ-010 limit  input  WIDTH  terminal value for a run.
REQ-011 a, b  input  CMP_W each  compare operands.
REQ-012 cnt  output  WIDTH  current count, registered.
REQ-013 busy  output  1  high in COUNT state.
REQ-014 done  output  1  one-cycle pulse when run reaches limit.
REQ-015 wrap  output  1  one-cycle pulse when cnt rolls all-ones to zero.
REQ-016 match  output  1  registered (a == b), updated every cycle.
REQ-017 gt  output  1  registered (a > b) unsigned, updated every cycle.

Function
REQ-018 FSM states IDLE, COUNT, DONE; all transitions on clk rising edge.
REQ-019 IDLE: start=1 and abort=0 -> COUNT; cnt unchanged unless load.
REQ-020 COUNT: abort=1 -> IDLE (highest priority); else cnt == limit and inhibit=0 -> DONE; else stay.
REQ-021 DONE: lasts exactly one cycle, done=1 during it, then unconditionally IDLE.
REQ-022 COUNT, inhibit=0, cnt != limit, no load: cnt increments by 1 modulo 2^WIDTH per cycle.
REQ-023 Increment from all-ones wraps to 0 with wrap=1 in the following cycle only; run continues.
REQ-024 inhibit=1 in COUNT: cnt held, no transition to DONE, wrap not asserted.
REQ-025 load=1 in any state: cnt <= load_val next cycle, overriding increment; FSM transition unaffected.
REQ-026 load and abort together: both take effect (cnt loaded, state IDLE).
REQ-027 start while in COUNT or DONE: ignored.
REQ-028 start with cnt already equal to limit: COUNT entered; DONE on next non-inhibited cycle; cnt not incremented.
REQ-029 busy = 1 iff state == COUNT; outputs decoded from registered state, no combinational input-to-output path.
REQ-030 match and gt: one-cycle latency from a/b, independent of FSM and inhibit.
REQ-031 limit sampled live each cycle; changing limit mid-run is legal and takes effect immediately.

Reset
REQ-032 rst=1 asynchronously forces state IDLE, cnt=0, busy=0, done=0, wrap=0, match=0, gt=0.
REQ-033 rst asserted mid-run: run abandoned, no done pulse; after release block waits in IDLE for start.
REQ-034 First rising edge after rst release behaves as a normal IDLE cycle.

Verification
REQ-035 WIDTH=9, load_val=0 loaded, limit=5, start pulse -> busy 1 for 6 cycles, cnt 0..5, done one cycle after cnt=5, then IDLE with cnt=5.
REQ-036 load_val=511, limit=2, start -> cnt 511,0,1,2; wrap pulse exactly once, in the cycle cnt=0; done after cnt=2.
REQ-037 limit=10, run, inhibit high 3 cycles at cnt=4 -> cnt holds 4 for 3 cycles; done delayed 3 cycles vs uninhibited run.
REQ-038 abort at cnt=3 -> next cycle busy=0, cnt=3, no done; later start resumes counting from 3.
REQ-039 rst asserted asynchronously between edges at cnt=7 -> cnt=0, busy=0 immediately, before next edge.
REQ-040 CMP_W=4, sweep all 256 (a,b) pairs -> match/gt equal reference compare one cycle later, during IDLE and COUNT alike.

Source files
------------

// File: rtl/lal_counter.sv
// Run/limit counter: IDLE -> COUNT -> DONE sequencer with load, inhibit and abort,
// plus a registered magnitude comparator that runs independently of the FSM.
module lal_counter #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned CMP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             inhibit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic [CMP_W-1:0] a,
   input  logic [CMP_W-1:0] b,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic             match,
   output logic             gt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             r_wrap;
   logic             w_wrap_nxt;
   logic             r_match;
   logic             r_gt;
   logic             w_at_limit;
   logic             w_advance;

   assign w_at_limit = (r_cnt == limit);

   // Abort also suppresses the increment so an aborted run keeps its count.
   assign w_advance = (r_state == ST_COUNT) && !abort && !inhibit && !w_at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_wrap  <= 1'b0;
         r_match <= 1'b0;
         r_gt    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
         r_match <= (a == b);
         r_gt    <= (a > b);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_state_nxt = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_at_limit && !inhibit) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;
      if (load) begin
         w_cnt_nxt = load_val;
      end else if (w_advance) begin
         w_cnt_nxt  = r_cnt + 1'b1;
         w_wrap_nxt = (r_cnt == '1);
      end
   end

   assign cnt   = r_cnt;
   assign busy  = (r_state == ST_COUNT);
   assign done  = (r_state == ST_DONE);
   assign wrap  = r_wrap;
   assign match = r_match;
   assign gt    = r_gt;

endmodule
